// File: rtl/noc_input_buffer.sv
// Per-port NoC router input stage: flit FIFO, head-flit decode and a wormhole
// tracker that holds the arbiter request from header to tail.
module noc_input_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        grant,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic [2:0]  flit_id,
  output logic [11:0] length,
  output logic        req,
  output logic [7:0]  drop_count
);

  localparam logic [2:0]  ID_HDR  = 3'b001;
  localparam logic [2:0]  ID_TAIL = 3'b100;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  typedef enum logic {IDLE, PACKET} state_t;

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  state_t        state_r;
  state_t        state_nx_s;
  logic [31:0]   dout_r;
  logic          dout_valid_r;
  logic [11:0]   length_r;
  logic [7:0]    drop_count_r;

  logic [31:0] head_s;
  logic [2:0]  head_id_s;
  logic        not_empty_s;
  logic        push_s;
  logic        pop_fwd_s;
  logic        discard_s;
  logic        pop_s;
  logic        req_s;

  assign head_s      = mem_r[rd_ptr_r];
  assign head_id_s   = head_s[31:29];
  assign not_empty_s = (count_r != '0);
  assign push_s      = din_valid && din_ready;
  assign pop_s       = pop_fwd_s || discard_s;

  assign din_ready   = (count_r != FULL_COUNT);
  assign flit_id     = not_empty_s ? head_id_s : 3'b000;
  assign length      = length_r;
  assign req         = req_s;
  assign dout        = dout_r;
  assign dout_valid  = dout_valid_r;
  assign drop_count  = drop_count_r;

  // Wormhole tracker: decides request, forwarded pops and stray-flit discards.
  always_comb begin
    state_nx_s = state_r;
    req_s      = 1'b0;
    pop_fwd_s  = 1'b0;
    discard_s  = 1'b0;
    case (state_r)
      IDLE: begin
        req_s = not_empty_s && (head_id_s == ID_HDR);
        if (not_empty_s && (head_id_s != ID_HDR)) begin
          discard_s = 1'b1;
        end else if (not_empty_s && grant) begin
          pop_fwd_s  = 1'b1;
          state_nx_s = PACKET;
        end else begin
          state_nx_s = IDLE;
        end
      end
      PACKET: begin
        // Request stays up across empty gaps so the grant is not lost mid-packet.
        req_s = 1'b1;
        if (not_empty_s && grant) begin
          pop_fwd_s  = 1'b1;
          state_nx_s = (head_id_s == ID_TAIL) ? IDLE : PACKET;
        end else begin
          state_nx_s = PACKET;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, pointers, occupancy and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      dout_r       <= 32'd0;
      dout_valid_r <= 1'b0;
      length_r     <= 12'd0;
      drop_count_r <= 8'd0;
    end else begin
      state_r <= state_nx_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_COUNT;
        2'b01:   count_r <= count_r - ONE_COUNT;
        default: count_r <= count_r;
      endcase
      if (not_empty_s && (head_id_s == ID_HDR)) begin
        length_r <= head_s[11:0];
      end
      if (discard_s && (drop_count_r != 8'd255)) begin
        drop_count_r <= drop_count_r + 8'd1;
      end
      dout_valid_r <= pop_fwd_s;
      if (pop_fwd_s) begin
        dout_r <= head_s;
      end
    end
  end

  // Flit storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule
